// File: rtl/sram_fi_bist.sv
// ============================================================================
// sram_fi_bist : 1RW + 1R SRAM model with stuck-at fault injection and March C- style BIST
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_fi_bist #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_WMASKS  = DATA_WIDTH / 8,
  parameter int NUM_FAULTS  = 4,
  localparam int IDX_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  localparam int BIT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [BIT_W-1:0]      cfg_bit,
  input  logic [1:0]            cfg_type,
  input  logic                  bist_start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] bist_fail_addr,
  output logic [15:0]           fault_hits
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W0_UP   = 3'd1,
    S_R0W1_UP = 3'd2,
    S_R1W0_DN = 3'd3,
    S_R0_UP   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] ft_addr_q [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] ft_addr_d [NUM_FAULTS];
  logic [BIT_W-1:0]      ft_bit_q  [NUM_FAULTS];
  logic [BIT_W-1:0]      ft_bit_d  [NUM_FAULTS];
  logic [1:0]            ft_type_q [NUM_FAULTS];
  logic [1:0]            ft_type_d [NUM_FAULTS];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [15:0]           hits_q, hits_d;
  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;

  logic [DATA_WIDTH-1:0] lane_bits;
  logic                  wr_en;
  logic                  port_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] wr_data_f;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] bist_rd;
  logic [DATA_WIDTH-1:0] bist_exp;
  logic                  bist_cmp;

  // Bits forced high / low at a given address by all active table entries.
  function automatic logic [DATA_WIDTH-1:0] sa1_mask(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FAULTS; i++)
      if (ft_type_q[i] == 2'b10 && ft_addr_q[i] == a) m[ft_bit_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sa0_mask(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FAULTS; i++)
      if (ft_type_q[i] == 2'b01 && ft_addr_q[i] == a) m[ft_bit_q[i]] = 1'b1;
    return m;
  endfunction

  // Stuck-at-0 is applied last so it wins over stuck-at-1 on the same bit.
  function automatic logic [DATA_WIDTH-1:0] apply_faults(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [ADDR_WIDTH-1:0] a);
    return (d | sa1_mask(a)) & ~sa0_mask(a);
  endfunction

  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
    assign lane_bits[8*g +: 8] = {8{wmask0[g]}};
  end

  always_comb begin
    port_we = !busy_q && !csb0 && !web0;
    wr_en   = port_we;
    wr_addr = addr0;
    wr_data = din0;
    wr_bits = lane_bits;
    if (state_q == S_W0_UP || state_q == S_R0W1_UP || state_q == S_R1W0_DN) begin
      wr_en   = 1'b1;
      wr_addr = baddr_q;
      wr_data = (state_q == S_R0W1_UP) ? '1 : '0;
      wr_bits = '1;
    end
    wr_data_f = apply_faults(wr_data, wr_addr);
    wr_hit    = port_we && (|((sa1_mask(wr_addr) | sa0_mask(wr_addr)) & wr_bits));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_bits) | (wr_data_f & wr_bits);
  end

  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      ft_addr_d[i] = ft_addr_q[i];
      ft_bit_d[i]  = ft_bit_q[i];
      ft_type_d[i] = ft_type_q[i];
    end
    if (cfg_we && (32'(cfg_idx) < NUM_FAULTS)) begin
      ft_addr_d[cfg_idx] = cfg_addr;
      ft_bit_d[cfg_idx]  = cfg_bit;
      ft_type_d[cfg_idx] = cfg_type;
    end
  end

  // Reads sample the array before this edge's write lands, giving old data on collision.
  always_comb begin
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    if (!busy_q && !csb0 && web0) dout0_d = apply_faults(mem[addr0], addr0);
    if (!busy_q && !csb1)         dout1_d = apply_faults(mem[addr1], addr1);
    hits_d = (wr_hit && hits_q != 16'hFFFF) ? hits_q + 16'd1 : hits_q;
  end

  always_comb begin
    bist_rd  = apply_faults(mem[baddr_q], baddr_q);
    bist_exp = (state_q == S_R1W0_DN) ? '1 : '0;
    bist_cmp = (state_q == S_R0W1_UP) || (state_q == S_R1W0_DN) || (state_q == S_R0_UP);

    state_d     = state_q;
    baddr_d     = baddr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bist_start) begin
          state_d     = S_W0_UP;
          baddr_d     = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      S_W0_UP: begin
        baddr_d = baddr_q + 1'b1;
        if (baddr_q == '1) state_d = S_R0W1_UP;
      end
      S_R0W1_UP: begin
        if (baddr_q == '1) state_d = S_R1W0_DN;
        else               baddr_d = baddr_q + 1'b1;
      end
      S_R1W0_DN: begin
        if (baddr_q == '0) state_d = S_R0_UP;
        else               baddr_d = baddr_q - 1'b1;
      end
      S_R0_UP: begin
        baddr_d = baddr_q + 1'b1;
        if (baddr_q == '1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bist_cmp && bist_rd != bist_exp) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = baddr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baddr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      hits_q      <= '0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        ft_addr_q[i] <= '0;
        ft_bit_q[i]  <= '0;
        ft_type_q[i] <= 2'b00;
      end
    end else begin
      state_q     <= state_d;
      baddr_q     <= baddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      hits_q      <= hits_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        ft_addr_q[i] <= ft_addr_d[i];
        ft_bit_q[i]  <= ft_bit_d[i];
        ft_type_q[i] <= ft_type_d[i];
      end
    end
  end

  assign dout0          = dout0_q;
  assign dout1          = dout1_q;
  assign bist_busy      = busy_q;
  assign bist_done      = done_q;
  assign bist_fail      = fail_q;
  assign bist_fail_addr = fail_addr_q;
  assign fault_hits     = hits_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_fi_bist.sv
// ============================================================================
// tb_sram_fi_bist : scoreboard bench for sram_fi_bist (port access, faults, BIST)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sram_fi_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = 4'h0;
  logic [4:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;
  logic [31:0] dout0, dout1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [4:0]  cfg_addr = '0;
  logic [4:0]  cfg_bit = '0;
  logic [1:0]  cfg_type = '0;
  logic        bist_start = 1'b0;
  logic        bist_busy, bist_done, bist_fail;
  logic [4:0]  bist_fail_addr;
  logic [15:0] fault_hits;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  typedef struct packed {
    logic        port;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  sram_fi_bist dut (
    .clk(clk), .rst_n(rst_n),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .cfg_type(cfg_type),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .bist_fail_addr(bist_fail_addr), .fault_hits(fault_hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    sb_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      if (s.port) check("dout1", dout1, s.exp);
      else        check("dout0", dout0, s.exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    @(negedge clk);
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    @(negedge clk);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; csb1 = 1'b0; addr1 = a;
    sb_q.push_back({1'b0, e});
    sb_q.push_back({1'b1, e});
    @(negedge clk);
    csb0 = 1'b1; csb1 = 1'b1;
    drain();
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [4:0] a, input logic [4:0] b,
                     input logic [1:0] t);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_bit = b; cfg_type = t;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts the march and counts busy cycles; issues a read of addr 3 mid-run
  // and, when inject is set, a port 0 write to faulted addr 20 late in the run.
  task automatic run_bist(input bit inject, output int cnt);
    @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    cnt = 0;
    while (bist_busy && cnt < 1000) begin
      csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
      if (cnt == 50) begin
        csb0 = 1'b0; addr0 = 5'd3; csb1 = 1'b0; addr1 = 5'd3;
      end
      if (inject && cnt == 110) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 5'd20; din0 = 32'h1234_5678; wmask0 = 4'hF;
        bist_start = 1'b1;
      end
      cnt++;
      @(negedge clk);
      bist_start = 1'b0;
    end
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
  endtask

  initial begin
    #3;
    check("rst_busy", {31'd0, bist_busy}, 32'd0);
    check("rst_done", {31'd0, bist_done}, 32'd0);
    check("rst_fail", {31'd0, bist_fail}, 32'd0);
    check("rst_hits", {16'd0, fault_hits}, 32'd0);
    check("rst_dout0", dout0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word write then dual-port read.
    wr(5'd3, 32'hA5A5_A5A5, 4'hF);
    rd(5'd3, 32'hA5A5_A5A5);

    // Port 1 read colliding with a port 0 write returns the old word.
    @(negedge clk);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 5'd3; din0 = 32'h1111_1111; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 5'd3;
    sb_q.push_back({1'b1, 32'hA5A5_A5A5});
    @(negedge clk);
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    drain();
    rd(5'd3, 32'h1111_1111);

    // Byte-lane masking.
    wr(5'd7, 32'hFFFF_FFFF, 4'hF);
    wr(5'd7, 32'h0000_0000, 4'b0010);
    rd(5'd7, 32'hFFFF_00FF);

    // Clean march: 128 busy cycles, reads during busy do not move dout.
    run_bist(1'b0, cyc);
    check("bist_cycles", cyc, 32'd128);
    check("bist_done", {31'd0, bist_done}, 32'd1);
    check("bist_fail", {31'd0, bist_fail}, 32'd0);
    check("hold_dout0", dout0, 32'hFFFF_00FF);
    check("hold_dout1", dout1, 32'hFFFF_00FF);
    check("bist_hits", {16'd0, fault_hits}, 32'd0);

    // Stuck-at-1 on addr 10 bit 8.
    cfg(2'd0, 5'd10, 5'd8, 2'b10);
    wr(5'd10, 32'h0, 4'hF);
    check("sa1_hits", {16'd0, fault_hits}, 32'd1);
    rd(5'd10, 32'h0000_0100);
    wr(5'd10, 32'h0, 4'b1101);
    check("sa1_hits_masked", {16'd0, fault_hits}, 32'd1);
    rd(5'd10, 32'h0000_0100);

    // Stuck-at-0 on the same bit overrides.
    cfg(2'd1, 5'd10, 5'd8, 2'b01);
    rd(5'd10, 32'h0000_0000);

    // Faulty march: first mismatch at addr 20 (descending element), port write ignored.
    cfg(2'd2, 5'd20, 5'd0, 2'b01);
    run_bist(1'b1, cyc);
    check("fbist_cycles", cyc, 32'd128);
    check("fbist_done", {31'd0, bist_done}, 32'd1);
    check("fbist_fail", {31'd0, bist_fail}, 32'd1);
    check("fbist_addr", {27'd0, bist_fail_addr}, 32'd20);
    check("fbist_hits", {16'd0, fault_hits}, 32'd1);
    rd(5'd20, 32'h0000_0000);

    // Reset in the middle of a march clears everything.
    @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy", {31'd0, bist_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bist_busy}, 32'd0);
    check("arst_fail", {31'd0, bist_fail}, 32'd0);
    check("arst_addr", {27'd0, bist_fail_addr}, 32'd0);
    check("arst_hits", {16'd0, fault_hits}, 32'd0);
    check("arst_dout1", dout1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", {31'd0, bist_busy}, 32'd0);
    check("post_rst_done", {31'd0, bist_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
